// File: rtl/mem_pkg.sv
// Shared types and defaults for the block-level data memory behind the cache controller.
package mem_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned ADDR_W          = 6;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned LATENCY_DEFAULT = 4;
  localparam int unsigned DEPTH_DEFAULT   = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_e;

  // Request captured at acceptance; isolates the access from later input changes.
  typedef struct packed {
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_req_t;

  // Counter preload so that the last ACCESS cycle sees a zero count.
  function automatic logic [CNT_W-1:0] latency_preload(input int unsigned latency);
    return CNT_W'(latency - 1);
  endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// Down-counter pacing the ACCESS phase: loadable, saturating at zero, with a zero flag.
module mem_latency_counter
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             decrement,
  output logic             zero_c
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (decrement && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/data_memory.sv
// Fixed-latency block data memory: accepts one read or write-back request at a time,
// completes it after LATENCY access cycles and signals completion with one busywait-low cycle.
module data_memory
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEFAULT,
  parameter int unsigned DEPTH   = DEPTH_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              busywait
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_state_e        state;
  mem_req_t          req;
  logic [DATA_W-1:0] mem [DEPTH];

  logic request_c;
  logic accept_c;
  logic access_c;
  logic complete_c;
  logic cnt_zero_c;
  logic in_range_c;
  logic [IDX_W-1:0] idx_c;

  assign request_c  = read | write;
  assign accept_c   = (state == IDLE) && request_c;
  assign access_c   = (state == ACCESS);
  assign complete_c = access_c && cnt_zero_c;
  assign in_range_c = (32'(req.addr) < DEPTH);
  assign idx_c      = IDX_W'(req.addr);

  mem_latency_counter #(
    .WIDTH (CNT_W)
  ) u_latency_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (accept_c),
    .load_value (latency_preload(LATENCY)),
    .decrement  (access_c),
    .zero_c     (cnt_zero_c)
  );

  // Control FSM; a simultaneous read and write resolves to a write.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      req   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request_c) begin
            req.is_write <= write;
            req.addr     <= address;
            req.data     <= writedata;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_zero_c) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage and read register; only touched on the final ACCESS edge, so reset aborts cleanly.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[IDX_W'(i)] <= '0;
      end
      readdata <= '0;
    end else if (complete_c) begin
      if (req.is_write) begin
        if (in_range_c) begin
          mem[idx_c] <= req.data;
        end
      end else begin
        readdata <= in_range_c ? mem[idx_c] : '0;
      end
    end
  end

  // Raised in the same cycle a request appears so the controller stalls immediately.
  always_comb begin
    busywait = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:    busywait = request_c;
        ACCESS:  busywait = 1'b1;
        default: busywait = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory with LATENCY=4: timing, data path, reset abort and request hold.
module tb_data_memory;
  import mem_pkg::*;

  logic              clock;
  logic              reset;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              busywait;

  int n_checks;
  int n_fail;

  data_memory #(
    .LATENCY (4),
    .DEPTH   (64)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .read      (read),
    .write     (write),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .busywait  (busywait)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 32'h%08h, expected 32'h%08h", tag, actual, expected);
    end
  endtask

  // Drive a request from just after an edge; returns busy cycle count and readdata in the done cycle.
  task automatic run_access(input logic rd, input logic wr, input logic [5:0] a,
                            input logic [31:0] d, output int busy_cnt, output logic [31:0] rd_val);
    read      = rd;
    write     = wr;
    address   = a;
    writedata = d;
    busy_cnt  = 0;
    rd_val    = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!busywait) break;
      busy_cnt++;
      @(posedge clock); #1;
    end
    rd_val = readdata;
    read   = 1'b0;
    write  = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic wait_idle(input string tag);
    int  n;
    n = 0;
    while (n < 40) begin
      @(negedge clock);
      if (!busywait) break;
      n++;
      @(posedge clock); #1;
    end
    if (n >= 40) check(tag, 32'(n), 32'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    int          busy;
    logic [31:0] rv;
    logic [11:0] pattern;
    logic [31:0] hold_rd;

    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    read      = 1'b1;
    write     = 1'b0;
    address   = 6'd0;
    writedata = '0;
    pattern   = '0;
    hold_rd   = '0;

    // Reset with a request pending: busywait must stay low.
    @(posedge clock); #1;
    @(negedge clock);
    check("busy_in_reset", 32'(busywait), 32'd0);
    check("readdata_reset", readdata, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    read  = 1'b0;

    // First cycle after reset: read of address 5.
    run_access(1'b1, 1'b0, 6'd5, 32'h0, busy, rv);
    check("rd5_busy_cycles", 32'(busy), 32'd5);
    check("rd5_data", rv, 32'h0);
    @(negedge clock);
    check("idle_busy_low", 32'(busywait), 32'd0);
    @(posedge clock); #1;

    run_access(1'b0, 1'b1, 6'd10, 32'hDEADBEEF, busy, rv);
    check("wr10_busy_cycles", 32'(busy), 32'd5);
    check("wr_keeps_readdata", rv, 32'h0);
    run_access(1'b1, 1'b0, 6'd10, 32'h0, busy, rv);
    check("rd10_busy_cycles", 32'(busy), 32'd5);
    check("rd10_data", rv, 32'hDEADBEEF);
    @(negedge clock);
    check("rd10_hold", readdata, 32'hDEADBEEF);
    @(posedge clock); #1;

    // Inputs change two cycles after acceptance of a write to 3.
    read      = 1'b0;
    write     = 1'b1;
    address   = 6'd3;
    writedata = 32'h12345678;
    @(posedge clock); #1;
    @(posedge clock); #1;
    address   = 6'd4;
    writedata = 32'hFFFFFFFF;
    wait_idle("wr3_timeout");
    write = 1'b0;
    run_access(1'b1, 1'b0, 6'd4, 32'h0, busy, rv);
    check("rd4_untouched", rv, 32'h0);
    run_access(1'b1, 1'b0, 6'd3, 32'h0, busy, rv);
    check("rd3_data", rv, 32'h12345678);

    // Reset in cycle 2 of a write to 7 aborts it and clears memory.
    write     = 1'b1;
    address   = 6'd7;
    writedata = 32'hA5A5A5A5;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("busy_reset_mid", 32'(busywait), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    write = 1'b0;
    @(negedge clock);
    check("busy_after_reset", 32'(busywait), 32'd0);
    check("readdata_cleared", readdata, 32'h0);
    @(posedge clock); #1;
    run_access(1'b1, 1'b0, 6'd7, 32'h0, busy, rv);
    check("rd7_aborted", rv, 32'h0);
    run_access(1'b1, 1'b0, 6'd3, 32'h0, busy, rv);
    check("rd3_cleared", rv, 32'h0);

    // Read and write together: write wins, readdata untouched.
    run_access(1'b0, 1'b1, 6'd20, 32'h11112222, busy, rv);
    run_access(1'b1, 1'b0, 6'd20, 32'h0, busy, rv);
    check("rd20_data", rv, 32'h11112222);
    run_access(1'b1, 1'b1, 6'd1, 32'h00FF00FF, busy, rv);
    check("rdwr_busy_cycles", 32'(busy), 32'd5);
    check("rdwr_keeps_readdata", rv, 32'h11112222);
    run_access(1'b1, 1'b0, 6'd1, 32'h0, busy, rv);
    check("rd1_data", rv, 32'h00FF00FF);

    // Read held through DONE: one low cycle, then a second access.
    run_access(1'b0, 1'b1, 6'd2, 32'hCAFEF00D, busy, rv);
    read    = 1'b1;
    address = 6'd2;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      pattern = {pattern[10:0], busywait};
      if (i == 5) hold_rd = readdata;
      if (i == 11) read = 1'b0;
      @(posedge clock); #1;
    end
    check("hold_busy_pattern", 32'(pattern), 32'h00000FBE);
    check("hold_rd2_data", hold_rd, 32'hCAFEF00D);
    @(negedge clock);
    check("hold_end_idle", 32'(busywait), 32'd0);
    check("hold_end_data", readdata, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter LATENCY, default 4, number of ACCESS cycles per request; legal range 1..15.
REQ-002 Parameter DEPTH, default 64, number of 32-bit blocks, i.e. 256 bytes total.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 read  input  1  block read request from the cache controller, held until busywait falls.
REQ-006 write  input  1  block write (write-back) request, held until busywait falls.
REQ-007 address  input  6  block address (byte address bits [7:2]).
REQ-008 writedata  input  32  block write data; byte 0 is bits [7:0], byte 3 is bits [31:24].
REQ-009 readdata  output  32  registered block read data.
REQ-010 busywait  output  1  high while a request is pending or in progress.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, ACCESS and DONE.
REQ-012 In IDLE, busywait SHALL equal (read | write) combinationally, so it is high in the same cycle the request appears.
REQ-013 At the IDLE edge with read|write=1, the block SHALL latch address, writedata and op, load counter = LATENCY-1, and enter ACCESS.
REQ-014 If read and write are both high at acceptance, the op SHALL be write, and readdata is unchanged.
REQ-015 In ACCESS, busywait SHALL be 1, and the counter SHALL decrement by 1 each edge with no wrap below 0.
REQ-016 At the ACCESS edge with counter==0, a write SHALL store the latched data to mem[latched address], a read SHALL load readdata from it, and the state SHALL go to DONE.
REQ-017 In DONE, busywait SHALL be 0 for exactly one cycle, then the state SHALL go to IDLE unconditionally.
REQ-018 Request in cycle 0 SHALL give busywait=1 in cycles 0..LATENCY, and busywait=0 with valid readdata in cycle LATENCY+1.
REQ-019 readdata SHALL hold its value until the next completed read, so it stays stable after busywait falls.
REQ-020 Changes to read, write, address or writedata after acceptance SHALL NOT affect the operation in progress.
REQ-021 Requests present in DONE SHALL be ignored; a request still asserted in the following IDLE cycle SHALL be accepted as a new access.
REQ-022 Back-to-back write then read of the same address SHALL return the newly written data.

Reset
REQ-023 On a reset edge, in any state including mid-ACCESS, state SHALL become IDLE, the counter 0, readdata 32'h0, and all DEPTH entries 32'h0.
REQ-024 An access interrupted by reset SHALL NOT modify memory.
REQ-025 During a reset cycle, busywait SHALL be 0 regardless of read/write.
REQ-026 A request present in the first cycle after reset deasserts SHALL be accepted normally.

Structure
REQ-027 The state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and the LATENCY and DEPTH defaults SHALL live in a shared package, mem_pkg.
REQ-028 The latency counter SHALL be the sub-module mem_latency_counter, with load, decrement and a zero flag; the storage array stays in data_memory.
REQ-029 busywait SHALL be the only combinational output; readdata SHALL be driven only by a register.

Verification
REQ-030 Reset, then read addr 6'd5 -> busywait high 5 cycles (LATENCY=4), then low, with readdata=32'h0.
REQ-031 Write addr 6'd10 data 32'hDEADBEEF, then read addr 6'd10 -> readdata=32'hDEADBEEF in cycle LATENCY+1 of the read.
REQ-032 Change address from 6'd3 to 6'd4 two cycles after accepting a write of 32'h12345678 to 6'd3 -> only mem[3] updated; a read of 6'd4 returns 32'h0.
REQ-033 Assert reset in cycle 2 of a write of 32'hA5A5A5A5 to 6'd7 -> next cycle busywait=0, and a later read of 6'd7 returns 32'h0.
REQ-034 Assert read and write together at 6'd1 with data 32'h00FF00FF -> write performed, and a later read returns 32'h00FF00FF.
REQ-035 Hold read high through DONE at 6'd2 -> one busywait-low cycle, then a second access is accepted with busywait high again.
